car_sequencer: RTL and testbench

- Control Address Register sequencer. Owns the registered CAR that addresses the microcode control ROM.
- Sits directly downstream of the CAR decoder. On an instruction-fetch boundary it loads the decoder's combinational CAR index, then steps through the microsequence until the ROM flags the last micro-op.
- Also sequences the reset-vector load, the interrupt-entry microsequence and illegal-opcode recovery.

---
 rtl/car_sequencer.sv | 148 ++++++++++++++
 tb/tb_car_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/car_sequencer.sv
// rtl/car_sequencer.sv - Control address register sequencer for the microcode control ROM
// Steps CAR through reset-vector, fetch, execute and interrupt-entry microsequences.
module car_sequencer #(
  parameter int CAR_BITS   = 6,
  parameter int CAR_FETCH  = 1,
  parameter int CAR_RESET0 = 2,
  parameter int RESET_LEN  = 3,
  parameter int CAR_INT0   = 5,
  parameter int INT_LEN    = 6
) (
  input  logic                MCLK,
  input  logic                RST_n,
  input  logic [CAR_BITS-1:0] CAR_DECODED,
  input  logic                IW_VALID,
  input  logic                SEQ_END,
  input  logic                STALL,
  input  logic                INT_REQ,
  output logic [CAR_BITS-1:0] CAR,
  output logic                INT_ACK,
  output logic                ILLEGAL,
  output logic                IN_FETCH
);

  localparam int CNT_MAX  = (RESET_LEN > INT_LEN) ? RESET_LEN : INT_LEN;
  localparam int CNT_BITS = $clog2(CNT_MAX) + 1;

  localparam logic [CAR_BITS-1:0] L_FETCH  = CAR_BITS'(CAR_FETCH);
  localparam logic [CAR_BITS-1:0] L_RESET0 = CAR_BITS'(CAR_RESET0);
  localparam logic [CAR_BITS-1:0] L_INT0   = CAR_BITS'(CAR_INT0);
  localparam logic [CNT_BITS-1:0] L_RESET_LAST = CNT_BITS'(RESET_LEN - 1);
  localparam logic [CNT_BITS-1:0] L_INT_LAST   = CNT_BITS'(INT_LEN - 1);

  // Both fixed microsequences must fit inside the control ROM address space.
  generate
    if (RESET_LEN < 1 || INT_LEN < 1 ||
        CAR_RESET0 + RESET_LEN > (1 << CAR_BITS) ||
        CAR_INT0 + INT_LEN > (1 << CAR_BITS)) begin : g_bad_params
      $error("car_sequencer: microsequence parameters exceed CAR address space");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_EXEC,
    S_INT
  } state_t;

  state_t              r_state;
  logic [CAR_BITS-1:0] r_car;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_int_ack;
  logic                r_illegal;
  logic                r_in_fetch;

  logic [CNT_BITS-1:0] w_cnt_inc;
  logic [CAR_BITS-1:0] w_car_inc;

  assign w_cnt_inc = r_cnt + CNT_BITS'(1);
  assign w_car_inc = r_car + CAR_BITS'(1);

  always_ff @(posedge MCLK) begin
    if (!RST_n) begin
      r_state    <= S_RESET;
      r_car      <= L_RESET0;
      r_cnt      <= '0;
      r_int_ack  <= 1'b0;
      r_illegal  <= 1'b0;
      r_in_fetch <= 1'b0;
    end else if (STALL) begin
      r_int_ack <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_int_ack <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_RESET: begin
          if (r_cnt == L_RESET_LAST) begin
            r_state    <= S_FETCH;
            r_car      <= L_FETCH;
            r_cnt      <= '0;
            r_in_fetch <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
            r_car <= L_RESET0 + CAR_BITS'(w_cnt_inc);
          end
        end
        S_FETCH: begin
          r_car <= L_FETCH;
          if (IW_VALID) begin
            if (CAR_DECODED != '0) begin
              r_state    <= S_EXEC;
              r_car      <= CAR_DECODED;
              r_in_fetch <= 1'b0;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (SEQ_END) begin
            if (INT_REQ) begin
              r_state   <= S_INT;
              r_car     <= L_INT0;
              r_cnt     <= '0;
              r_int_ack <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_car      <= L_FETCH;
              r_in_fetch <= 1'b1;
            end
          end else if (&r_car) begin
            // Running off the top of the ROM is treated as a bad microprogram, not a wrap.
            r_state    <= S_FETCH;
            r_car      <= L_FETCH;
            r_illegal  <= 1'b1;
            r_in_fetch <= 1'b1;
          end else begin
            r_car <= w_car_inc;
          end
        end
        S_INT: begin
          if (r_cnt == L_INT_LAST) begin
            r_state    <= S_FETCH;
            r_car      <= L_FETCH;
            r_cnt      <= '0;
            r_in_fetch <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
            r_car <= L_INT0 + CAR_BITS'(w_cnt_inc);
          end
        end
        default: begin
          r_state    <= S_FETCH;
          r_car      <= L_FETCH;
          r_cnt      <= '0;
          r_in_fetch <= 1'b1;
        end
      endcase
    end
  end

  assign CAR      = r_car;
  assign INT_ACK  = r_int_ack;
  assign ILLEGAL  = r_illegal;
  assign IN_FETCH = r_in_fetch;

endmodule

// File: tb/tb_car_sequencer.sv
// tb/tb_car_sequencer.sv - Randomized scoreboard bench for car_sequencer
// Transactions expand into per-step input/expected-output plans; a monitor checks each cycle.
module tb_car_sequencer;

  localparam int FETCH = 1;
  localparam int R0    = 2;
  localparam int RLEN  = 3;
  localparam int I0    = 5;
  localparam int ILEN  = 6;

  logic       MCLK;
  logic       RST_n;
  logic [5:0] CAR_DECODED;
  logic       IW_VALID;
  logic       SEQ_END;
  logic       STALL;
  logic       INT_REQ;
  logic [5:0] CAR;
  logic       INT_ACK;
  logic       ILLEGAL;
  logic       IN_FETCH;

  car_sequencer dut (
    .MCLK(MCLK), .RST_n(RST_n), .CAR_DECODED(CAR_DECODED), .IW_VALID(IW_VALID),
    .SEQ_END(SEQ_END), .STALL(STALL), .INT_REQ(INT_REQ), .CAR(CAR),
    .INT_ACK(INT_ACK), .ILLEGAL(ILLEGAL), .IN_FETCH(IN_FETCH)
  );

  typedef struct {
    logic [5:0] car;
    logic       ack;
    logic       ill;
    logic       inf;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       iw;
    logic [5:0] dec;
    logic       se;
    logic       ir;
    exp_t       e;
  } step_t;

  step_t plan[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  function automatic exp_t mk(input int car, input bit ack, input bit ill, input bit inf);
    exp_t e;
    e.car = 6'(car); e.ack = ack; e.ill = ill; e.inf = inf;
    return e;
  endfunction

  task automatic add(input bit rst, input bit iw, input int dec, input bit se, input bit ir,
                     input exp_t e);
    step_t s;
    s.rst = rst; s.iw = iw; s.dec = 6'(dec); s.se = se; s.ir = ir; s.e = e;
    plan.push_back(s);
  endtask

  // Reset pulse followed by the reset-vector walk into fetch; all other inputs are noise.
  task automatic add_reset();
    add(1, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1), 1, mk(R0, 0, 0, 0));
    for (int c = 1; c < RLEN; c++)
      add(0, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1),
          $urandom_range(0, 1), mk(R0 + c, 0, 0, 0));
    add(0, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1),
        $urandom_range(0, 1), mk(FETCH, 0, 0, 1));
  endtask

  task automatic add_idle(input int idle);
    for (int k = 0; k < idle; k++)
      add(0, 0, $urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 1),
          mk(FETCH, 0, 0, 1));
  endtask

  task automatic add_illegal(input int idle);
    add_idle(idle);
    add(0, 1, 0, $urandom_range(0, 1), $urandom_range(0, 1), mk(FETCH, 0, 1, 1));
  endtask

  // One instruction: D is the entry address, L the microsequence length, intr the
  // interrupt request at the boundary; a nonzero cut truncates the plan and resets there.
  task automatic add_instr(input int d, input int len, input bit intr, input int idle,
                           input int cut);
    int start;
    int car;
    start = plan.size();
    add_idle(idle);
    add(0, 1, d, $urandom_range(0, 1), $urandom_range(0, 1), mk(d, 0, 0, 0));
    car = d;
    for (int i = 0; i < len + 64; i++) begin
      if (i == len - 1) begin
        if (intr) begin
          add(0, $urandom_range(0, 1), $urandom_range(0, 63), 1, 1, mk(I0, 1, 0, 0));
          for (int c = 1; c < ILEN; c++)
            add(0, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1),
                $urandom_range(0, 1), mk(I0 + c, 0, 0, 0));
          add(0, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1),
              $urandom_range(0, 1), mk(FETCH, 0, 0, 1));
        end else begin
          add(0, $urandom_range(0, 1), $urandom_range(0, 63), 1, 0, mk(FETCH, 0, 0, 1));
        end
        break;
      end
      if (car == 63) begin
        add(0, $urandom_range(0, 1), $urandom_range(0, 63), 0, $urandom_range(0, 1),
            mk(FETCH, 0, 1, 1));
        break;
      end
      car = car + 1;
      add(0, $urandom_range(0, 1), $urandom_range(0, 63), 0, $urandom_range(0, 1),
          mk(car, 0, 0, 0));
    end
    if (cut > 0 && start + cut < plan.size()) begin
      while (plan.size() > start + cut) void'(plan.pop_back());
      add_reset();
    end
  endtask

  always begin
    exp_t got;
    exp_t want;
    @(posedge MCLK);
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = mk(CAR, INT_ACK, ILLEGAL, IN_FETCH);
      n_checks++;
      if (got == want) n_pass++;
      else
        $display("FAIL outputs at %0t: got CAR=%0d ACK=%0b ILL=%0b INF=%0b, expected CAR=%0d ACK=%0b ILL=%0b INF=%0b",
                 $time, got.car, got.ack, got.ill, got.inf, want.car, want.ack, want.ill, want.inf);
    end
  end

  initial begin
    step_t s;
    exp_t  last;
    int    r;
    int    bound;
    RST_n = 1'b0; STALL = 1'b0; IW_VALID = 1'b0; SEQ_END = 1'b0;
    INT_REQ = 1'b1; CAR_DECODED = '0;
    last = mk(R0, 0, 0, 0);

    add(1, 0, 0, 0, 1, mk(R0, 0, 0, 0));
    add_reset();
    add_instr(20, 4, 0, 1, 0);
    add_instr(20, 4, 1, 0, 0);
    add_illegal(1);
    add_instr(62, 10, 0, 0, 0);
    add_instr(20, 1, 1, 0, 4);
    for (int t = 0; t < 70; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) add_illegal($urandom_range(0, 2));
      else add_instr((r == 1) ? $urandom_range(56, 63) : $urandom_range(1, 63),
                     $urandom_range(1, 8), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                     ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 0);
    end

    while (plan.size() > 0) begin
      @(negedge MCLK);
      if (!plan[0].rst && $urandom_range(0, 4) == 0) begin
        RST_n = 1'b1; STALL = 1'b1;
        IW_VALID = 1'($urandom_range(0, 1)); SEQ_END = 1'($urandom_range(0, 1));
        INT_REQ = 1'($urandom_range(0, 1)); CAR_DECODED = 6'($urandom_range(0, 63));
        last.ack = 1'b0; last.ill = 1'b0;
        exp_q.push_back(last);
      end else begin
        s = plan.pop_front();
        RST_n = !s.rst;
        STALL = s.rst ? 1'($urandom_range(0, 1)) : 1'b0;
        IW_VALID = s.iw; CAR_DECODED = s.dec; SEQ_END = s.se; INT_REQ = s.ir;
        last = s.e;
        exp_q.push_back(last);
      end
    end

    bound = 0;
    while (exp_q.size() > 0 && bound < 10) begin
      @(posedge MCLK);
      bound++;
    end
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected outputs never compared, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
